// File: rtl/axi_fpgaware_ver_id_checker.sv
// AXI4-Lite read master that fetches the FPGA version/ID word, compares it against
// an expected value and retries on error responses under a per-attempt watchdog.
module axi_fpgaware_ver_id_checker #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    WSTRB_WIDTH    = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] ID_ADDR        = 32'h7000_0000,
  parameter int                    MAX_RETRIES    = 3,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                   m_axi_aclk,
  input  logic                   m_axi_areset,
  input  logic                   i_start,
  input  logic [DATA_WIDTH-1:0]  i_expected_id,
  output logic                   m_axi_awvalid,
  output logic [ADDR_WIDTH-1:0]  m_axi_awaddr,
  output logic                   m_axi_wvalid,
  output logic [DATA_WIDTH-1:0]  m_axi_wdata,
  output logic [WSTRB_WIDTH-1:0] m_axi_wstrb,
  output logic                   m_axi_bready,
  input  logic                   m_axi_bvalid,
  input  logic [1:0]             m_axi_bresp,
  output logic                   m_axi_arvalid,
  output logic [ADDR_WIDTH-1:0]  m_axi_araddr,
  input  logic                   m_axi_arready,
  input  logic                   m_axi_rvalid,
  input  logic [DATA_WIDTH-1:0]  m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  output logic                   m_axi_rready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [DATA_WIDTH-1:0]  o_id_value,
  output logic                   o_match,
  output logic                   o_error,
  output logic                   o_timeout,
  output logic [1:0]             o_attempts
);

  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]     ATT_MAX = 2'(MAX_RETRIES);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] expected_id;
  logic [WD_W-1:0]       wd_cnt;
  logic                  unused_b;

  // write channel is never used; keep it quiescent
  assign m_axi_awvalid = 1'b0;
  assign m_axi_awaddr  = '0;
  assign m_axi_wvalid  = 1'b0;
  assign m_axi_wdata   = '0;
  assign m_axi_wstrb   = '0;
  assign m_axi_bready  = 1'b1;
  assign m_axi_araddr  = ID_ADDR;
  assign unused_b      = ^{m_axi_bvalid, m_axi_bresp};

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state         <= IDLE;
      expected_id   <= '0;
      wd_cnt        <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_id_value    <= '0;
      o_match       <= 1'b0;
      o_error       <= 1'b0;
      o_timeout     <= 1'b0;
      o_attempts    <= 2'd0;
    end else begin
      o_done <= 1'b0;

      // watchdog only observes; the transaction keeps waiting after it fires
      if (state != IDLE && wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + WD_W'(1);
        if (wd_cnt == WD_MAX - WD_W'(1)) o_timeout <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            state         <= ADDR;
            expected_id   <= i_expected_id;
            o_match       <= 1'b0;
            o_error       <= 1'b0;
            o_timeout     <= 1'b0;
            wd_cnt        <= '0;
            o_attempts    <= 2'd1;
            m_axi_arvalid <= 1'b1;
            o_busy        <= 1'b1;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= DATA;
          end
        end
        DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            o_id_value   <= m_axi_rdata;
            if (m_axi_rresp == 2'b00) begin
              state   <= IDLE;
              o_match <= (m_axi_rdata == expected_id);
              o_error <= 1'b0;
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
            end else if (o_attempts < ATT_MAX) begin
              state         <= ADDR;
              o_attempts    <= o_attempts + 2'd1;
              wd_cnt        <= '0;
              m_axi_arvalid <= 1'b1;
            end else begin
              state   <= IDLE;
              o_error <= 1'b1;
              o_match <= 1'b0;
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_fpgaware_ver_id_checker.sv
// Directed and randomized checks of the ID checker against a response-list model
// of retry, match, error and watchdog outcomes.
module tb_axi_fpgaware_ver_id_checker;

  localparam logic [31:0] IDA = 32'h7000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_expected_id;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_bvalid;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata, o_id_value;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp, o_attempts;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic        o_busy, o_done, o_match, o_error, o_timeout;

  int errors = 0;
  int checks = 0;
  logic [1:0]  rsp_q[4];
  logic [31:0] dat_q[4];
  int ar_dly, r_dly;

  always #5 clk = ~clk;

  axi_fpgaware_ver_id_checker dut (
    .m_axi_aclk(clk), .m_axi_areset(rst), .i_start(i_start), .i_expected_id(i_expected_id),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_bready(m_axi_bready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_araddr(m_axi_araddr), .m_axi_arready(m_axi_arready), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rready(m_axi_rready),
    .o_busy(o_busy), .o_done(o_done), .o_id_value(o_id_value), .o_match(o_match),
    .o_error(o_error), .o_timeout(o_timeout), .o_attempts(o_attempts)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // outcome from the response list: first OKAY within 3 attempts wins, else error
  task automatic model(input logic [31:0] e, output int att, output bit err,
                       output bit mt, output logic [31:0] v);
    bit found = 0;
    att = 3; err = 1; mt = 0; v = dat_q[2];
    for (int i = 0; i < 3; i++) begin
      if (!found && rsp_q[i] == 2'b00) begin
        found = 1; att = i + 1; err = 0; mt = (dat_q[i] == e); v = dat_q[i];
      end
    end
  endtask

  task automatic start_run(input string tag, input logic [31:0] e);
    i_start = 1'b1; i_expected_id = e;
    @(negedge clk);
    i_start = 1'b0;
    chk({tag, "_arvalid_after_start"}, m_axi_arvalid, 1);
    chk({tag, "_busy_after_start"}, o_busy, 1);
  endtask

  task automatic serve(input string tag, input logic [31:0] e, input bit poke,
                       input bit exp_to, input bit chain);
    int cyc = 0, wa = 0, wr = 0, k = 0, ar_cnt = 0, drops = 0;
    bit prev_req = 0;
    int att; bit err, mt; logic [31:0] v;
    model(e, att, err, mt, v);
    while (!o_done && cyc < 2000) begin
      if (prev_req && !m_axi_arvalid) drops++;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; i_start = 1'b0; prev_req = 0;
      if (m_axi_arvalid) begin
        if (exp_to && wa == 255) chk({tag, "_timeout_before"}, o_timeout, 0);
        if (exp_to && wa == 256) chk({tag, "_timeout_at"}, o_timeout, 1);
        if (poke && wa == 1) begin i_start = 1'b1; i_expected_id = ~e; end
        if (wa >= ar_dly) begin m_axi_arready = 1'b1; wa = 0; ar_cnt++; end
        else begin wa++; prev_req = 1; end
      end else if (m_axi_rready) begin
        if (wr >= r_dly) begin
          m_axi_rvalid = 1'b1; m_axi_rdata = dat_q[k]; m_axi_rresp = rsp_q[k];
          if (k < 3) k++;
          wr = 0;
        end else wr++;
      end
      @(negedge clk); cyc++;
    end
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; i_start = 1'b0;
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_ar_count"}, ar_cnt, att);
    chk({tag, "_attempts"}, o_attempts, att);
    chk({tag, "_error"}, o_error, err);
    chk({tag, "_match"}, o_match, mt);
    chk({tag, "_id_value"}, o_id_value, v);
    chk({tag, "_timeout"}, o_timeout, exp_to);
    chk({tag, "_busy_at_done"}, o_busy, 0);
    chk({tag, "_arvalid_drops"}, drops, 0);
    if (!chain) begin
      @(negedge clk);
      chk({tag, "_done_single"}, o_done, 0);
    end
  endtask

  initial begin
    logic [31:0] e;
    rst = 1'b1; i_start = 1'b0; i_expected_id = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_bvalid = 1'b0; m_axi_bresp = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", o_busy, 0);       chk("rst_done", o_done, 0);
    chk("rst_id", o_id_value, 0);     chk("rst_match", o_match, 0);
    chk("rst_error", o_error, 0);     chk("rst_timeout", o_timeout, 0);
    chk("rst_attempts", o_attempts, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("araddr", m_axi_araddr, IDA);
    chk("tie_aw", {m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, 0);
    chk("tie_bready", m_axi_bready, 1);

    // matching ID, single attempt
    ar_dly = 1; r_dly = 1;
    rsp_q = '{2'b00, 2'b00, 2'b00, 2'b00};
    dat_q = '{32'h0123_4567, 32'h0, 32'h0, 32'h0};
    start_run("t1", 32'h0123_4567); serve("t1", 32'h0123_4567, 0, 0, 0);

    // mismatching ID
    dat_q[0] = 32'h89AB_CDEF;
    start_run("t2", 32'h0123_4567); serve("t2", 32'h0123_4567, 0, 0, 0);

    // two errors then success
    rsp_q = '{2'b10, 2'b10, 2'b00, 2'b00};
    dat_q = '{32'hDEAD_0001, 32'hDEAD_0002, 32'h0123_4567, 32'h0};
    start_run("t3", 32'h0123_4567); serve("t3", 32'h0123_4567, 0, 0, 0);

    // all attempts fail
    rsp_q = '{2'b10, 2'b11, 2'b10, 2'b00};
    dat_q = '{32'h0123_4567, 32'h0123_4567, 32'hBAD0_0003, 32'h0123_4567};
    start_run("t4", 32'h0123_4567); serve("t4", 32'h0123_4567, 0, 0, 0);

    // stalled address channel trips the watchdog
    ar_dly = 300;
    rsp_q = '{2'b00, 2'b00, 2'b00, 2'b00};
    dat_q = '{32'h0123_4567, 32'h0, 32'h0, 32'h0};
    start_run("t5", 32'h0123_4567); serve("t5", 32'h0123_4567, 0, 1, 0);

    // reset while waiting for read data, with minimum address latency
    start_run("t6a", 32'h0123_4567);
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    chk("t6a_rready_min_latency", m_axi_rready, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6a_rst_rready", m_axi_rready, 0);
    chk("t6a_rst_arvalid", m_axi_arvalid, 0);
    chk("t6a_rst_done", o_done, 0);
    chk("t6a_rst_busy", o_busy, 0);
    chk("t6a_rst_flags", {o_id_value, o_match, o_error, o_timeout, o_attempts}, 0);

    // start while busy is ignored
    ar_dly = 3; r_dly = 0;
    start_run("t6b", 32'h0123_4567); serve("t6b", 32'h0123_4567, 1, 0, 1);

    // start in the done cycle begins a new run
    dat_q[0] = 32'h5555_AAAA;
    start_run("t6c", 32'h5555_AAAA); serve("t6c", 32'h5555_AAAA, 0, 0, 0);

    // randomized responses
    for (int n = 0; n < 20; n++) begin
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        rsp_q[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        dat_q[i] = $urandom;
      end
      e = $urandom_range(0, 1) ? dat_q[$urandom_range(0, 2)] : $urandom;
      start_run("rnd", e); serve("rnd", e, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_fpgaware_ver_id_checker.md
Name: axi_fpgaware_ver_id_checker

Overview:
- AXI4-Lite read master that sits directly upstream of the FPGA version/ID register slave.
- On a start pulse it reads the ID register at ID_ADDR and compares the returned word with an expected ID.
- It reports value, match, error and timeout status to a system supervisor or boot sequencer.
- It retries on non-OKAY responses, up to MAX_RETRIES attempts in total.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width
WSTRB_WIDTH, DATA_WIDTH/8, write strobe width (write channel tie-off only)
ID_ADDR, 32'h70000000, address of the ID register
MAX_RETRIES, 3, total read attempts allowed per start (>=1)
TIMEOUT_CYCLES, 256, watchdog threshold in cycles per attempt (>=2)

Ports:
m_axi_aclk  in  1  clock
m_axi_areset  in  1  reset; synchronous, active-high
i_start  in  1  start pulse; sampled only in IDLE
i_expected_id  in  DATA_WIDTH  reference ID; sampled on accepted start
m_axi_awvalid/m_axi_wvalid  out  1  tied 0
m_axi_awaddr  out  ADDR_WIDTH  tied 0
m_axi_wdata  out  DATA_WIDTH  tied 0
m_axi_wstrb  out  WSTRB_WIDTH  tied 0
m_axi_bready  out  1  tied 1
m_axi_bvalid/m_axi_bresp  in  1/2  ignored
m_axi_arvalid  out  1  read address valid
m_axi_araddr  out  ADDR_WIDTH  read address (ID_ADDR)
m_axi_arready  in  1  read address ready
m_axi_rvalid  in  1  read data valid
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rready  out  1  read data ready
o_busy  out  1  transaction in progress
o_done  out  1  one-cycle completion pulse
o_id_value  out  DATA_WIDTH  last captured rdata
o_match  out  1  last result OKAY and rdata == expected
o_error  out  1  all attempts returned non-OKAY
o_timeout  out  1  sticky watchdog flag
o_attempts  out  2  attempts used in last/current run

Behaviour:
- Reset (synchronous, registered): state IDLE, all registered outputs 0. araddr holds ID_ADDR constantly. Asserting reset mid-transaction drops arvalid/rready at the next edge, no completion pulse.
- FSM states: IDLE, ADDR, DATA. All outputs registered.
- IDLE:
  - i_start=1 -> ADDR.
  - Latch i_expected_id; clear o_match, o_error, o_timeout, watchdog counter; o_attempts=1.
  - arvalid=1 from the next cycle. o_busy=1 in ADDR and DATA.
- ADDR:
  - arvalid=1, held until arvalid&arready (AXI rule: never withdrawn).
  - On handshake -> DATA, arvalid=0, rready=1 next cycle.
  - Minimum latency: start at cycle 0, arvalid at cycle 1, arready at cycle 1 -> rready at cycle 2.
- DATA:
  - rready=1 until rvalid&rready; capture rdata into o_id_value at that edge.
  - rresp==OKAY(2'b00): -> IDLE; o_match = (rdata == latched expected); o_error=0; o_done=1 for one cycle; o_busy=0.
  - rresp!=OKAY and o_attempts<MAX_RETRIES: -> ADDR; o_attempts+1; watchdog cleared; no o_done.
  - rresp!=OKAY and o_attempts==MAX_RETRIES: -> IDLE; o_error=1; o_match=0; o_done pulse.
- Watchdog:
  - Counts every cycle in ADDR/DATA and saturates.
  - Reaching TIMEOUT_CYCLES sets o_timeout (sticky until next accepted start).
  - The FSM keeps waiting; no protocol violation.
- Ignored inputs: i_start while busy. An i_start in the o_done cycle is accepted (state already IDLE).
- Results hold until the next accepted start. bvalid/bresp are unused.

Test Plan:
1. Start with i_expected_id=0x01234567; slave returns 0x01234567 OKAY after arready/rvalid delay 1 -> single AR, o_done once, o_match=1, o_id_value=0x01234567, o_attempts=1, o_error=0.
2. Slave returns 0x89ABCDEF OKAY, expected 0x01234567 -> o_match=0, o_error=0, o_id_value=0x89ABCDEF.
3. Slave returns SLVERR twice then OKAY 0x01234567 -> three AR handshakes, o_attempts=3, o_match=1, one o_done; arvalid never dropped before arready.
4. Slave returns SLVERR three times -> o_error=1, o_match=0, o_done after third R; no fourth AR.
5. arready held low 300 cycles, TIMEOUT_CYCLES=256 -> o_timeout=1 at cycle 256 of ADDR, arvalid stays 1; completes normally once arready rises, o_timeout still 1.
6. Reset asserted in DATA state; start pulsed while busy; start in the o_done cycle -> reset: outputs 0, no o_done. Busy start: ignored. o_done-cycle start: new run begins, arvalid next cycle.
